// File: rtl/counter_share_pkg.sv
// Shared types and helpers for the round-robin counter-sharing scheduler.
// Latency: none (declarations and a combinational helper only).
// Backpressure: n/a.
package counter_share_pkg;

    localparam int DEF_WIDTH = 7;
    // Widest requester vector the round-robin helper handles.
    localparam int MAXREQ    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Return the first requester with req set, scanning upward from last_ptr+1
    // and wrapping at nreq. The result is don't-care when req is all-zero.
    function automatic logic [2:0] rr_pick(input logic [MAXREQ-1:0] req,
                                           input logic [2:0]        last_ptr,
                                           input int unsigned       nreq);
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAXREQ; k++) begin
            idx = {29'd0, last_ptr} + k;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if ((k <= nreq) && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/counter_share_ctrl_if.sv
// Request/grant bundle between requesters and the counter-sharing scheduler.
// Latency: none (wires only).
// Backpressure: requesters hold req until done or drop it to abort.
interface counter_share_ctrl_if
    import counter_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [NREQ-1:0]       done;
    logic                  abort;
    logic [WIDTH-1:0]      q;

    // Requester side.
    modport master (
        output req, len,
        input  grant, busy, done, abort, q
    );

    // Scheduler side.
    modport slave (
        input  req, len,
        output grant, busy, done, abort, q
    );
endinterface

// File: rtl/share_counter.sv
// Shared WIDTH-bit up-counter; clear wins over enable.
// Latency: 1 cycle from clr/en to q.
// Backpressure: none; enable and clear are owned by the scheduler FSM.
module share_counter
    import counter_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // Count up while enabled; clear returns to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_share_ctrl.sv
// Round-robin scheduler granting one requester an exclusive window of the shared counter.
// Latency: grant 1 cycle after req seen in IDLE; window of L takes L+2 cycles to next grant.
// Backpressure: requests outside IDLE wait; owner dropping req during RUN aborts the window.
module counter_share_ctrl
    import counter_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic reset,
    counter_share_ctrl_if.slave bus
);

    state_t           state;
    logic [NREQ-1:0]  grant_r;
    logic [2:0]       owner;
    logic [2:0]       last_ptr;
    logic [2:0]       pick;
    logic [WIDTH-1:0] len_l;
    logic [WIDTH-1:0] len_pick;
    logic [WIDTH-1:0] q;
    logic             abort_r;
    logic             owner_req;
    logic             run_last;
    logic             cnt_clr;
    logic             cnt_en;

    // Winner selection, its length slice, and RUN exit conditions.
    always_comb begin
        pick     = rr_pick(MAXREQ'(bus.req), last_ptr, NREQ);
        len_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == i[2:0]) begin
                len_pick = bus.len[i*WIDTH +: WIDTH];
            end
        end
        // len_l is never zero in RUN, so the subtraction cannot underflow there.
        owner_req = |(bus.req & grant_r);
        run_last  = (q == (len_l - WIDTH'(1)));
        cnt_en    = (state == RUN);
        // Counter sits at zero except while a live window is still counting.
        cnt_clr   = (state != RUN) || !owner_req || run_last;
    end

    // Scheduler state machine: arbitrate in IDLE, count in RUN, signal in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_r  <= '0;
            owner    <= '0;
            last_ptr <= 3'(NREQ - 1);
            len_l    <= '0;
            abort_r  <= 1'b0;
        end else begin
            abort_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner   <= pick;
                        grant_r <= NREQ'(1) << pick;
                        len_l   <= len_pick;
                        state   <= (len_pick == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // An abort takes precedence even on the final counting cycle.
                    if (!owner_req) begin
                        state    <= IDLE;
                        grant_r  <= '0;
                        abort_r  <= 1'b1;
                        last_ptr <= owner;
                    end else if (run_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    grant_r  <= '0;
                    last_ptr <= owner;
                end
                default: begin
                    state   <= IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    share_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (q)
    );

    assign bus.grant = grant_r;
    assign bus.busy  = (state == RUN) || (state == DONE);
    assign bus.done  = (state == DONE) ? grant_r : '0;
    assign bus.abort = abort_r;
    assign bus.q     = q;

endmodule
